ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles allowed between prefix byte and final byte.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two), key-event queue entries.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port code_valid  in  1  one-cycle strobe: received scan-code byte on code.
REQ-006 SHALL have port code  in  8  scan-code byte, valid only with code_valid.
REQ-007 SHALL have port ev_valid  out  1  event queue non-empty.
REQ-008 SHALL have port ev_ready  in  1  consumer accepts head event.
REQ-009 SHALL have port ev_code  out  8  head event scan code (prefix bytes stripped).
REQ-010 SHALL have port ev_ext  out  1  head event carried an E0 prefix.
REQ-011 SHALL have port ev_break  out  1  head event is a release (F0 prefix).
REQ-012 SHALL have port ev_shift  out  1  shift XOR caps state when the event was formed.
REQ-013 SHALL have ports shift_st, caps_st  out  1 each  live modifier state.
REQ-014 SHALL have port ovf  out  1  sticky flag: event dropped because queue was full.
REQ-015 SHALL have port ovf_clr  in  1  clears ovf.
REQ-016 SHALL have port busy  out  1  high while the FSM is in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXT, BRK, EXT_BRK; transitions only on code_valid or timeout.
REQ-018 On code E0: any state -> EXT (a partial sequence is discarded).
REQ-019 On code F0: IDLE->BRK, EXT->EXT_BRK, BRK and EXT_BRK hold their state.
REQ-020 On any other code: form event {code, ext=state in EXT/EXT_BRK, break=state in BRK/EXT_BRK}, then -> IDLE.
REQ-021 Timeout counter SHALL clear on every code_valid and in IDLE, and SHALL count in other states; at TIMEOUT_CYC-1 the FSM -> IDLE with no event.
REQ-022 Non-extended code 12 or 59: make sets, break clears shift_st (one bit per key; shift_st = OR of both).
REQ-023 Non-extended make of 58 SHALL toggle caps_st; the break of 58 has no effect on caps_st.
REQ-024 ev_shift SHALL be sampled from the modifier state before the current event updates it.
REQ-025 Typematic suppression: held register {ext, code, vld}; a make equal to a valid held value is dropped; any other make loads held; a break equal to held clears vld.
REQ-026 Surviving events SHALL be pushed into the FIFO in the cycle after the final code_valid; ev_valid SHALL rise one cycle after the push when the queue was empty.
REQ-027 Pop SHALL occur when ev_valid && ev_ready; ev_* SHALL hold the head event stable while ev_valid && !ev_ready.
REQ-028 A push into a full queue with no same-cycle pop SHALL drop the event and set ovf; a push and pop in the same cycle when full SHALL both succeed.
REQ-029 ovf_clr SHALL clear ovf; if ovf_clr and an overflow occur in the same cycle, set wins.
REQ-030 FIFO pointers SHALL use log2(FIFO_DEPTH)+1 bits with natural wrap; full/empty are derived from the MSB comparison.

Reset
REQ-031 On rst low: FSM=IDLE, timer=0, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_shift=0, shift_st=0, caps_st=0, held vld=0, ovf=0, busy=0.
REQ-032 Reset asserted mid-sequence SHALL discard the partial sequence and the whole queue.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, the codes E0/F0/12/59/58, and the event record type {code[7:0], ext, brk, shift}.
REQ-034 The queue SHALL be a single sub-module ps2_ev_fifo (parameter DEPTH, width 11) with push/pop/full/empty.

Verification
REQ-035 Bytes 1C -> event code=1C ext=0 break=0; bytes F0,1C -> code=1C break=1; the held register is cleared.
REQ-036 Bytes E0,F0,75 -> code=75 ext=1 break=1; busy is high for the two prefix bytes, then low.
REQ-037 Bytes 12, 1C, 1C, F0,1C, F0,12 -> 4 events: shift make, 1C with ev_shift=1, 1C break, shift break; the second 1C is suppressed.
REQ-038 Byte E0, then no further byte for TIMEOUT_CYC cycles -> FSM returns to IDLE; a following 1C yields ext=0.
REQ-039 ev_ready=0 with 5 distinct makes (FIFO_DEPTH=4) -> 4 queued in order, ovf=1; ovf_clr -> ovf=0; draining yields the first 4 codes.
REQ-040 rst low after byte F0 -> all outputs reset; a following 1C yields break=0.

Source files
------------

// File: rtl/ps2_key_ctrl_pkg.sv
// Shared types for the PS/2 key controller: FSM states, scan-code constants, event record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_key_ctrl_pkg;

    // Prefix-tracking states of the scan-code decoder
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // One decoded key event as stored in the queue
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       shift;
    } ev_t;

    localparam int EV_W = $bits(ev_t);

endpackage

// File: rtl/ps2_ev_fifo.sv
// Generic first-word-fall-through queue with extra-MSB pointers for full/empty.
// Latency: push visible at dout one cycle after the write edge; pop is combinational head advance.
// Backpressure: push into a full queue is ignored unless a pop happens in the same cycle.
// Ports: clk/rst (async active-low), push/din, pop, dout (head), full, empty.
module ps2_ev_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index bits with differing wrap bit means the writer lapped the reader
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the head slot, so a full queue can still take the push
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes, tracks shift/caps, suppresses typematic repeats, queues events.
// Latency: event enters the queue the cycle after its final byte; ev_valid rises one cycle later when the queue was empty.
// Backpressure: ev_valid/ev_ready handshake on the head; a full queue drops new events and sets sticky ovf.
// Ports: clk, rst (async active-low), code_valid/code in; ev_valid/ev_ready/ev_code/ev_ext/ev_break/ev_shift event head;
//        shift_st/caps_st live modifiers; ovf/ovf_clr overflow flag; busy = prefix sequence in progress.
module ps2_key_ctrl
    import ps2_key_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_shift,
    output logic       shift_st,
    output logic       caps_st,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic       busy
);

    localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] tmr;
    logic          timeout;

    logic          fin;       // current byte completes a sequence
    logic          fin_ext;
    logic          fin_brk;

    logic [7:0]    held_code;
    logic          held_ext;
    logic          held_vld;
    logic          held_hit;
    logic          keep;      // formed event survives repeat suppression

    logic          lshift;
    logic          rshift;

    ev_t           pend;
    logic          pend_vld;

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EV_W-1:0] fifo_dout;
    ev_t           head;

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    assign timeout = (state != ST_IDLE) && (tmr == TMO_LAST);

    always_comb begin
        next_state = state;
        fin        = 1'b0;
        if (code_valid) begin
            if (code == CODE_EXT) begin
                // A fresh E0 restarts the sequence regardless of what came before
                next_state = ST_EXT;
            end else if (code == CODE_BRK) begin
                case (state)
                    ST_IDLE: next_state = ST_BRK;
                    ST_EXT:  next_state = ST_EXT_BRK;
                    default: next_state = state;
                endcase
            end else begin
                fin        = 1'b1;
                next_state = ST_IDLE;
            end
        end else if (timeout) begin
            next_state = ST_IDLE;
        end
    end

    assign fin_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign fin_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign busy    = (state != ST_IDLE);

    // Inter-byte timer: only runs while a prefix is pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (code_valid || (state == ST_IDLE) || timeout) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Typematic suppression and modifier tracking
    // ------------------------------------------------------------------
    assign held_hit = held_vld && (held_ext == fin_ext) && (held_code == code);
    // Breaks always pass; a make is dropped only when it repeats the held key
    assign keep     = fin && (fin_brk || !held_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_code <= '0;
            held_ext  <= 1'b0;
            held_vld  <= 1'b0;
        end else if (fin) begin
            if (!fin_brk && !held_hit) begin
                held_code <= code;
                held_ext  <= fin_ext;
                held_vld  <= 1'b1;
            end else if (fin_brk && held_hit) begin
                held_vld  <= 1'b0;
            end
        end
    end

    // Modifiers follow surviving events only, so an auto-repeating caps key
    // toggles once per physical press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lshift  <= 1'b0;
            rshift  <= 1'b0;
            caps_st <= 1'b0;
        end else if (keep && !fin_ext) begin
            if (code == CODE_LSHIFT) lshift <= !fin_brk;
            if (code == CODE_RSHIFT) rshift <= !fin_brk;
            if ((code == CODE_CAPS) && !fin_brk) caps_st <= !caps_st;
        end
    end

    assign shift_st = lshift || rshift;

    // Event staging: shift flag captures the modifier state before this byte's update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else begin
            pend_vld   <= keep;
            pend.code  <= code;
            pend.ext   <= fin_ext;
            pend.brk   <= fin_brk;
            pend.shift <= shift_st ^ caps_st;
        end
    end

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    assign push = pend_vld;
    assign pop  = ev_valid && ev_ready;

    ps2_ev_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (pend),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Queue storage is not reset, so the head is masked while the queue is empty
    assign head     = fifo_dout;
    assign ev_valid = !fifo_empty;
    assign ev_code  = ev_valid ? head.code  : 8'h00;
    assign ev_ext   = ev_valid && head.ext;
    assign ev_break = ev_valid && head.brk;
    assign ev_shift = ev_valid && head.shift;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: scoreboard of expected events popped as the DUT hands them over.
// Latency: n/a.
// Backpressure: bench drives ev_ready to exercise stall, overflow and drain.
module tb_ps2_key_ctrl;

    localparam int TMO   = 64;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_shift;
    logic       shift_st;
    logic       caps_st;
    logic       ovf;
    logic       busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q [$];
    logic [10:0] exp_ev;

    ps2_key_ctrl #(
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_shift   (ev_shift),
        .shift_st   (shift_st),
        .caps_st    (caps_st),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ev(input logic [7:0] c, input logic e, input logic b, input logic s);
        return {c, e, b, s};
    endfunction

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 code_valid = 1'b1;
        code = b;
        @(posedge clk);
        #1 code_valid = 1'b0;
        code = 8'h00;
    endtask

    task automatic expect_ev(input logic [10:0] e);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 check("drain_valid", {31'b0, ev_valid}, 0);
    endtask

    // Scoreboard consumer: every accepted handshake must match the oldest expectation
    always @(negedge clk) begin
        if (rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", exp_q.size(), 1);
            end else begin
                exp_ev = exp_q.pop_front();
                check("event", {21'b0, ev_code, ev_ext, ev_break, ev_shift}, {21'b0, exp_ev});
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ev_valid", {31'b0, ev_valid}, 0);
        check("rst_ev_code",  {24'b0, ev_code},  0);
        check("rst_ev_flags", {29'b0, ev_ext, ev_break, ev_shift}, 0);
        check("rst_mods",     {30'b0, shift_st, caps_st}, 0);
        check("rst_ovf",      {31'b0, ovf}, 0);
        check("rst_busy",     {31'b0, busy}, 0);
        rst = 1'b1;
        ev_ready = 1'b1;

        // Plain make/break; the break clears the held key so a new make passes
        expect_ev(ev(8'h1C, 0, 0, 0));
        send(8'h1C);
        expect_ev(ev(8'h1C, 0, 1, 0));
        send(8'hF0); send(8'h1C);
        expect_ev(ev(8'h1C, 0, 0, 0));
        send(8'h1C);
        expect_ev(ev(8'h1C, 0, 1, 0));
        send(8'hF0); send(8'h1C);
        drain();

        // Extended break, busy through the prefixes
        expect_ev(ev(8'h75, 1, 1, 0));
        send(8'hE0);
        check("busy_after_e0", {31'b0, busy}, 1);
        send(8'hF0);
        check("busy_after_f0", {31'b0, busy}, 1);
        send(8'h75);
        check("busy_after_75", {31'b0, busy}, 0);
        drain();

        // Shift tracking and typematic suppression
        expect_ev(ev(8'h12, 0, 0, 0));
        send(8'h12);
        #20 check("shift_set", {31'b0, shift_st}, 1);
        expect_ev(ev(8'h1C, 0, 0, 1));
        send(8'h1C);
        send(8'h1C);
        expect_ev(ev(8'h1C, 0, 1, 1));
        send(8'hF0); send(8'h1C);
        expect_ev(ev(8'h12, 0, 1, 1));
        send(8'hF0); send(8'h12);
        #20 check("shift_clr", {31'b0, shift_st}, 0);
        drain();

        // Caps toggles on make only
        expect_ev(ev(8'h58, 0, 0, 0));
        send(8'h58);
        check("caps_on", {31'b0, caps_st}, 1);
        expect_ev(ev(8'h58, 0, 1, 1));
        send(8'hF0); send(8'h58);
        check("caps_hold_on_break", {31'b0, caps_st}, 1);
        expect_ev(ev(8'h58, 0, 0, 1));
        send(8'h58);
        check("caps_off", {31'b0, caps_st}, 0);
        expect_ev(ev(8'h58, 0, 1, 0));
        send(8'hF0); send(8'h58);
        drain();

        // Prefix timeout
        send(8'hE0);
        repeat (TMO - 4) @(posedge clk);
        #1 check("busy_before_tmo", {31'b0, busy}, 1);
        repeat (8) @(posedge clk);
        #1 check("busy_after_tmo", {31'b0, busy}, 0);
        expect_ev(ev(8'h1C, 0, 0, 0));
        send(8'h1C);
        drain();

        // Overflow with stalled consumer
        ev_ready = 1'b0;
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_set",        {31'b0, ovf}, 1);
        check("stall_valid",    {31'b0, ev_valid}, 1);
        check("stall_head",     {24'b0, ev_code}, 32'h15);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        check("ovf_clr",        {31'b0, ovf}, 0);
        check("stall_head_hold", {24'b0, ev_code}, 32'h15);
        expect_ev(ev(8'h15, 0, 0, 0));
        expect_ev(ev(8'h1D, 0, 0, 0));
        expect_ev(ev(8'h24, 0, 0, 0));
        expect_ev(ev(8'h2D, 0, 0, 0));
        ev_ready = 1'b1;
        drain();

        // Reset mid-sequence discards queue and prefix
        ev_ready = 1'b0;
        send(8'h33);
        send(8'hF0);
        check("busy_pre_rst", {31'b0, busy}, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_valid", {31'b0, ev_valid}, 0);
        check("mid_rst_busy",  {31'b0, busy}, 0);
        check("mid_rst_code",  {24'b0, ev_code}, 0);
        check("mid_rst_mods",  {30'b0, shift_st, caps_st}, 0);
        rst = 1'b1;
        ev_ready = 1'b1;
        expect_ev(ev(8'h1C, 0, 0, 0));
        send(8'h1C);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
